// File: rtl/mirfak_clint_pkg.sv
// Shared constants and address decode for the Mirfak core-local interruptor.
package mirfak_clint_pkg;

   localparam logic [15:0] CLINT_MSIP        = 16'h0000;
   localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
   localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
   localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
   localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

   localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef enum logic [2:0] {
      REG_NONE,
      REG_MSIP,
      REG_CMP_LO,
      REG_CMP_HI,
      REG_TIME_LO,
      REG_TIME_HI
   } clint_reg_e;

   // Byte-lane bits [1:0] are masked off, so any byte address inside a word hits it.
   function automatic clint_reg_e clint_decode(input logic [15:0] addr);
      logic [15:0] word;
      word = addr & 16'hFFFC;
      case (word)
         CLINT_MSIP:        return REG_MSIP;
         CLINT_MTIMECMP_LO: return REG_CMP_LO;
         CLINT_MTIMECMP_HI: return REG_CMP_HI;
         CLINT_MTIME_LO:    return REG_TIME_LO;
         CLINT_MTIME_HI:    return REG_TIME_HI;
         default:           return REG_NONE;
      endcase
   endfunction

endpackage

// File: rtl/mirfak_clint_timer.sv
// 64-bit mtime counter with byte-enabled half-word write ports.
// Optional tick prescaler enabled by MIRFAK_CLINT_PRESCALER_EN.
module mirfak_clint_timer #(
   parameter int unsigned DIVIDER = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        wr_lo,
   input  logic        wr_hi,
   input  logic [31:0] wdata,
   input  logic [3:0]  wsel,
   output logic [63:0] mtime
);

   logic [63:0] mtime_reg;
   logic [63:0] mtime_next;
   logic [31:0] lo_merged;
   logic [31:0] hi_merged;
   logic        tick;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_byte
         assign lo_merged[gi*8 +: 8] = wsel[gi] ? wdata[gi*8 +: 8] : mtime_reg[gi*8 +: 8];
         assign hi_merged[gi*8 +: 8] = wsel[gi] ? wdata[gi*8 +: 8] : mtime_reg[32 + gi*8 +: 8];
      end
   endgenerate

`ifdef MIRFAK_CLINT_PRESCALER_EN
   localparam int unsigned PW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(DIVIDER - 1);

   logic [PW-1:0] presc_reg;
   logic [PW-1:0] presc_next;

   assign tick = (presc_reg == PRESC_MAX);

   // A software write to mtime restarts the tick period from zero.
   always_comb begin
      presc_next = presc_reg + PW'(1);
      if (tick || wr_lo || wr_hi) begin
         presc_next = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         presc_reg <= '0;
      end else begin
         presc_reg <= presc_next;
      end
   end
`else
   // DIVIDER is at least 1, so this is a tick on every cycle.
   assign tick = (DIVIDER != 0);
`endif

   always_comb begin
      mtime_next = mtime_reg;
      if (wr_lo || wr_hi) begin
         if (wr_lo) begin
            mtime_next[31:0] = lo_merged;
         end
         if (wr_hi) begin
            mtime_next[63:32] = hi_merged;
         end
      end else if (tick) begin
         mtime_next = mtime_reg + 64'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mtime_reg <= '0;
      end else begin
         mtime_reg <= mtime_next;
      end
   end

   assign mtime = mtime_reg;

endmodule

// File: rtl/mirfak_clint.sv
// Core-local interruptor: Wishbone B4 classic slave with msip, mtimecmp and mtime.
// Build option: MIRFAK_CLINT_PRESCALER_EN enables the DIVIDER tick prescaler.
module mirfak_clint #(
   parameter int unsigned DIVIDER = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [15:0] wbs_addr_i,
   input  logic [31:0] wbs_dat_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   output logic [31:0] wbs_dat_o,
   output logic        wbs_ack_o,
   output logic        wbs_err_o,
   output logic        xint_msip_o,
   output logic        xint_mtip_o
);

   import mirfak_clint_pkg::*;

   logic        ack_reg;
   logic        err_reg;
   logic [31:0] dat_reg;
   logic        msip_reg;
   logic [63:0] mtimecmp_reg;
   logic        mtip_reg;

   logic        req;
   logic        wr_en;
   clint_reg_e  reg_sel;
   logic [31:0] rdata;
   logic [31:0] cmp_lo_merged;
   logic [31:0] cmp_hi_merged;
   logic [63:0] mtime;
   logic        time_wr_lo;
   logic        time_wr_hi;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_byte
         assign cmp_lo_merged[gi*8 +: 8] = wbs_sel_i[gi] ? wbs_dat_i[gi*8 +: 8]
                                                         : mtimecmp_reg[gi*8 +: 8];
         assign cmp_hi_merged[gi*8 +: 8] = wbs_sel_i[gi] ? wbs_dat_i[gi*8 +: 8]
                                                         : mtimecmp_reg[32 + gi*8 +: 8];
      end
   endgenerate

   // A request is taken only while no response is outstanding, giving a 2-cycle cadence.
   always_comb begin
      req     = wbs_cyc_i & wbs_stb_i & ~ack_reg & ~err_reg;
      reg_sel = clint_decode(wbs_addr_i);
      wr_en   = req & wbs_we_i;
      rdata   = '0;
      case (reg_sel)
         REG_MSIP:    rdata = {31'b0, msip_reg};
         REG_CMP_LO:  rdata = mtimecmp_reg[31:0];
         REG_CMP_HI:  rdata = mtimecmp_reg[63:32];
         REG_TIME_LO: rdata = mtime[31:0];
         REG_TIME_HI: rdata = mtime[63:32];
         default:     rdata = '0;
      endcase
   end

   // An all-zero byte enable leaves mtime counting normally.
   assign time_wr_lo = wr_en && (reg_sel == REG_TIME_LO) && (wbs_sel_i != 4'b0000);
   assign time_wr_hi = wr_en && (reg_sel == REG_TIME_HI) && (wbs_sel_i != 4'b0000);

   mirfak_clint_timer #(
      .DIVIDER (DIVIDER)
   ) u_timer (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .wr_lo  (time_wr_lo),
      .wr_hi  (time_wr_hi),
      .wdata  (wbs_dat_i),
      .wsel   (wbs_sel_i),
      .mtime  (mtime)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ack_reg      <= 1'b0;
         err_reg      <= 1'b0;
         dat_reg      <= '0;
         msip_reg     <= 1'b0;
         mtimecmp_reg <= MTIMECMP_RST;
         mtip_reg     <= 1'b0;
      end else begin
         ack_reg  <= 1'b0;
         err_reg  <= 1'b0;
         mtip_reg <= (mtime >= mtimecmp_reg);
         if (req) begin
            if (reg_sel == REG_NONE) begin
               err_reg <= 1'b1;
               dat_reg <= '0;
            end else begin
               ack_reg <= 1'b1;
               dat_reg <= rdata;
            end
         end
         if (wr_en) begin
            case (reg_sel)
               REG_MSIP: begin
                  if (wbs_sel_i[0]) begin
                     msip_reg <= wbs_dat_i[0];
                  end
               end
               REG_CMP_LO: mtimecmp_reg[31:0]  <= cmp_lo_merged;
               REG_CMP_HI: mtimecmp_reg[63:32] <= cmp_hi_merged;
               default: ;
            endcase
         end
      end
   end

   assign wbs_ack_o   = ack_reg;
   assign wbs_err_o   = err_reg;
   assign wbs_dat_o   = dat_reg;
   assign xint_msip_o = msip_reg;
   assign xint_mtip_o = mtip_reg;

endmodule

// File: doc/mirfak_clint.md
# mirfak_clint

Core-local interruptor for the Mirfak core: a Wishbone B4 classic slave holding the machine software-interrupt bit, the 64-bit `mtime` counter and the 64-bit `mtimecmp` compare register. It drives the `msip`/`mtip` interrupt lines consumed by the core's CSR file. It sits on the data bus next to memory, one instance per hart.

## Interface
- `DIVIDER`, default 1: `mtime` tick period in `clk_i` cycles, minimum 1; used only with `MIRFAK_CLINT_PRESCALER_EN`.
- `clk_i`  in  1  system clock
- `rst_ni`  in  1  reset, asynchronous assert, active-low
- `wbs_addr_i`  in  16  byte address within the CLINT window; bits [1:0] ignored
- `wbs_dat_i`  in  32  write data
- `wbs_sel_i`  in  4  byte enables
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1  Wishbone cycle, strobe and write enable
- `wbs_dat_o`  out  32  read data, registered, valid with ack
- `wbs_ack_o`  out  1  transfer complete
- `wbs_err_o`  out  1  unmapped address
- `xint_msip_o`  out  1  machine software interrupt
- `xint_mtip_o`  out  1  machine timer interrupt

## Operation
- Register map (word offsets):
  - 0x0000 `msip`: bit 0 R/W, bits [31:1] read 0.
  - 0x4000 / 0x4004 `mtimecmp` lo/hi.
  - 0xBFF8 / 0xBFFC `mtime` lo/hi.
  - Any other address: `wbs_err_o` instead of ack, no state change, `wbs_dat_o` = 0.
- Reset values: `msip`=0, `mtime`=0, `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF, all outputs 0.
- Writes honour `wbs_sel_i` per byte. `sel`=0 still acks with no change.
- `mtime` increments by 1 per tick and wraps from 2^64-1 to 0. Carry from lo propagates into hi.
- Bus write to `mtime` lo or hi on a tick cycle: the written half takes the bus data, the other half holds, and no increment occurs that cycle.
- `xint_mtip_o` = registered (`mtime` >= `mtimecmp`), unsigned 64-bit compare. It is level, cleared only by raising `mtimecmp` or writing `mtime`.
- `xint_msip_o` = `msip` bit 0, driven directly from the register.
- 64-bit reads are not atomic. Software reads hi, lo, hi and retries on mismatch.

## Timing
- Request is accepted when `cyc & stb & !ack & !err`. `wbs_ack_o` or `wbs_err_o` pulses for exactly 1 cycle on the following cycle.
- Back-to-back requests therefore complete every 2 cycles.
- Register update happens on the same edge that raises ack. Read data reflects the state before that edge.
- `xint_msip_o` changes the cycle after the write edge, simultaneously with ack.
- `xint_mtip_o` lags the write edge or the `mtime` crossing by 1 further cycle (compare output is registered).
- Dropping `cyc` mid-transfer: the pending ack is still issued. Masters ignore it.
- `rst_ni` low at any time immediately returns all state to reset values, including an in-flight ack.

## Configuration
- `MIRFAK_CLINT_PRESCALER_EN` defined: a counter 0..`DIVIDER`-1 generates a tick on wrap; `DIVIDER`=1 is equivalent to a tick every cycle. A write to `mtime` resets the prescaler to 0.
- Undefined: tick every cycle, no prescaler logic, `DIVIDER` ignored.

## Structure
- Shared package `mirfak_clint_pkg`: address offset constants (`CLINT_MSIP`, `CLINT_MTIMECMP_LO/HI`, `CLINT_MTIME_LO/HI`) and the `mtimecmp` reset constant.
- Sub-module `mirfak_clint_timer`:
  - contains the 64-bit `mtime` counter, the optional prescaler and the half-word write ports;
  - outputs `mtime`.
- The top level holds bus decode, `msip`, `mtimecmp` and the compare.

## Test plan
- Reset, then read all four timer words and `msip` -> `mtimecmp`=FFFFFFFF/FFFFFFFF, `msip`=0, `mtime` small and increasing, both irq outputs 0.
- Write 1 to 0x0000 -> `xint_msip_o`=1 with ack; write 0 -> 0. Read of 0x0000 after writing FFFFFFFF -> 00000001.
- Write `mtime`=0, `mtimecmp` hi=0 then lo=20 -> `xint_mtip_o` rises when `mtime` reaches 20 (+1 cycle). Writing lo=1000 -> falls 1 cycle after the write edge.
- Write `mtime` lo=FFFFFFFE, hi=0 -> after 2 ticks hi=1, lo=0.
- Write with `sel`=4'b0010, data 0x0000AB00, to `mtimecmp` lo=FFFFFFFF -> reads FFFFABFF.
- Access 0x1234 -> `wbs_err_o` pulse, no ack, no state change. With prescaler, `DIVIDER`=4 -> `mtime` advances 1 per 4 cycles.
